// File: rtl/la_pkg.sv
// ============================================================================
// Module      : la_pkg
// Description : Shared constants for the UART transmit-path arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package la_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic REQ_DUMP = 1'b0;
    localparam logic REQ_CMD  = 1'b1;

    function automatic logic [1:0] owner_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_watchdog.sv
// ============================================================================
// Module      : tx_watchdog
// Description : Clear/enable saturating counter that flags a stalled owner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_watchdog #(
    parameter int              TO_W           = 16,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] C_ONE = {{(TO_W-1){1'b0}}, 1'b1};

    logic [TO_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != TIMEOUT_CYCLES)) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign expired = (r_count == TIMEOUT_CYCLES);

endmodule

`default_nettype wire

// File: rtl/tx_arbiter.sv
// ============================================================================
// Module      : tx_arbiter
// Description : Round-robin owner arbitration of the shared UART TX byte path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_arbiter
    import la_pkg::*;
#(
    parameter int              TO_W           = 16,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant,
    input  logic [1:0] done,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    input  logic       tx_valid0,
    input  logic       tx_valid1,
    output logic       tx_ack0,
    output logic       tx_ack1,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ack,
    output logic       busy,
    output logic       timeout_err
);

    logic [1:0] r_state;
    logic       r_owner;
    logic       r_last_owner;
    logic [1:0] r_grant;
    logic       r_timeout_err;

    logic w_start;
    logic w_pick;
    logic w_end;
    logic w_expired;

    assign w_start = (r_state == ST_IDLE) && (req != 2'b00);
    // On a tie the requester that did not own the previous session wins.
    assign w_pick  = (req == 2'b11) ? ~r_last_owner : req[REQ_CMD];
    assign w_end   = done[r_owner] || !req[r_owner];

    tx_watchdog #(
        .TO_W           (TO_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_start | tx_ack),
        .en      (r_state == ST_GRANT),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_owner       <= REQ_DUMP;
            r_last_owner  <= REQ_CMD;
            r_grant       <= 2'b00;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state      <= ST_GRANT;
                        r_owner      <= w_pick;
                        r_last_owner <= w_pick;
                        r_grant      <= owner_onehot(w_pick);
                    end
                end
                ST_GRANT: begin
                    // A normal end or abort takes precedence over the watchdog.
                    if (w_end) begin
                        r_state <= ST_RELEASE;
                        r_grant <= 2'b00;
                    end else if (w_expired) begin
                        r_state       <= ST_RELEASE;
                        r_grant       <= 2'b00;
                        r_timeout_err <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        tx_data  = 8'd0;
        tx_valid = 1'b0;
        tx_ack0  = 1'b0;
        tx_ack1  = 1'b0;
        if (r_state == ST_GRANT) begin
            if (r_owner == REQ_DUMP) begin
                tx_data  = tx_data0;
                tx_valid = tx_valid0;
                tx_ack0  = tx_ack;
            end else begin
                tx_data  = tx_data1;
                tx_valid = tx_valid1;
                tx_ack1  = tx_ack;
            end
        end
    end

    assign grant       = r_grant;
    assign busy        = (r_state != ST_IDLE);
    assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_tx_arbiter.sv
// ============================================================================
// Module      : tb_tx_arbiter
// Description : Directed and randomized checks of tx_arbiter against a session model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_arbiter;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] done;
    logic [7:0] tx_data0, tx_data1, tx_data;
    logic       tx_valid0, tx_valid1, tx_valid;
    logic       tx_ack0, tx_ack1, tx_ack;
    logic       busy, timeout_err;

    int n_vec = 0;
    int n_err = 0;

    // Session-level reference: who owns the path, cool-down gap, stall count.
    bit m_act;
    bit m_own;
    bit m_last;
    int m_gap;
    int m_idle;
    bit m_terr;

    always #5 clk = ~clk;

    tx_arbiter #(
        .TO_W           (16),
        .TIMEOUT_CYCLES (16'd16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .done        (done),
        .tx_data0    (tx_data0),
        .tx_data1    (tx_data1),
        .tx_valid0   (tx_valid0),
        .tx_valid1   (tx_valid1),
        .tx_ack0     (tx_ack0),
        .tx_ack1     (tx_ack1),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ack      (tx_ack),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req = 2'b00; done = 2'b00; tx_ack = 1'b0;
        tx_data0 = 8'd0; tx_data1 = 8'd0; tx_valid0 = 1'b0; tx_valid1 = 1'b0;
    endtask

    task automatic reset_dut;
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic model_reset;
        m_act = 0; m_own = 0; m_last = 1; m_gap = 0; m_idle = 0; m_terr = 0;
    endtask

    task automatic model_update;
        if (!rst) begin
            model_reset();
        end else begin
            m_terr = 0;
            if (m_act) begin
                if (done[m_own] || !req[m_own]) begin
                    m_act = 0; m_gap = 1;
                end else if (m_idle == TO) begin
                    m_act = 0; m_gap = 1; m_terr = 1;
                end else if (tx_ack) begin
                    m_idle = 0;
                end else begin
                    m_idle = m_idle + 1;
                end
            end else if (m_gap > 0) begin
                m_gap = m_gap - 1;
            end else if (req != 2'b00) begin
                m_own  = (req == 2'b11) ? !m_last : req[1];
                m_last = m_own;
                m_act  = 1;
                m_idle = 0;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        clear_inputs();
        tick();
        @(negedge clk);
        n_vec++;
        if ({grant, busy, timeout_err} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got grant/busy/terr=%b expected 0000", {grant, busy, timeout_err});
        end
        n_vec++;
        if ({tx_valid, tx_data, tx_ack0, tx_ack1} !== 11'b0) begin
            n_err++;
            $display("FAIL reset_path: got valid/data/acks=%b expected 0", {tx_valid, tx_data, tx_ack0, tx_ack1});
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_single;
        reset_dut();
        req = 2'b01; tx_data1 = 8'hEE; tx_valid1 = 1'b1;
        @(negedge clk);
        n_vec++;
        if (grant !== 2'b00) begin
            n_err++; $display("FAIL single_pre_grant: got %b expected 00", grant);
        end
        tick();
        n_vec++;
        if (grant !== 2'b01) begin
            n_err++; $display("FAIL single_grant_latency: got %b expected 01", grant);
        end
        for (int b = 1; b <= 4; b++) begin
            tx_data0 = 8'(b); tx_valid0 = 1'b1; tx_ack = 1'b0;
            @(negedge clk);
            n_vec++;
            if ({tx_valid, tx_data, tx_ack0, tx_ack1} !== {1'b1, 8'(b), 2'b00}) begin
                n_err++;
                $display("FAIL single_byte%0d: got valid=%b data=%h acks=%b%b expected 1 %h 00",
                         b, tx_valid, tx_data, tx_ack0, tx_ack1, 8'(b));
            end
            tick();
            tx_ack = 1'b1;
            @(negedge clk);
            n_vec++;
            if ({tx_ack0, tx_ack1, tx_data} !== {2'b10, 8'(b)}) begin
                n_err++;
                $display("FAIL single_ack%0d: got acks=%b%b data=%h expected 10 %h",
                         b, tx_ack0, tx_ack1, tx_data, 8'(b));
            end
            tick();
            tx_ack = 1'b0;
        end
        tx_valid0 = 1'b0;
        done = 2'b01;
        tick();
        done = 2'b00;
        n_vec++;
        if ({grant, busy} !== 3'b001) begin
            n_err++; $display("FAIL single_release: got grant=%b busy=%b expected 00 1", grant, busy);
        end
        tick();
        n_vec++;
        if ({grant, busy} !== 3'b000) begin
            n_err++; $display("FAIL single_idle: got grant=%b busy=%b expected 00 0", grant, busy);
        end
        tick();
        n_vec++;
        if (grant !== 2'b01) begin
            n_err++; $display("FAIL single_regrant: got %b expected 01", grant);
        end
        clear_inputs();
        repeat (3) tick();
    endtask

    task automatic test_tie_after_reset;
        logic [1:0] exp_seq [3];
        int k;
        exp_seq = '{2'b01, 2'b10, 2'b01};
        rst = 1'b0;
        clear_inputs();
        tick();
        rst = 1'b1;
        req = 2'b11;
        for (int s = 0; s < 3; s++) begin
            k = 0;
            while (grant == 2'b00 && k < 6) begin
                tick();
                k++;
            end
            n_vec++;
            if (grant !== exp_seq[s]) begin
                n_err++; $display("FAIL tie_session%0d: got %b expected %b", s, grant, exp_seq[s]);
            end
            if (s > 0) begin
                n_vec++;
                if (k != 2) begin
                    n_err++; $display("FAIL tie_gap%0d: got %0d low cycles expected 2", s, k);
                end
            end
            done = grant;
            tick();
            done = 2'b00;
        end
        clear_inputs();
        repeat (3) tick();
    endtask

    task automatic test_nonowner_done;
        reset_dut();
        req = 2'b01;
        tick();
        done = 2'b10;
        tick();
        done = 2'b00;
        n_vec++;
        if ({grant, busy, timeout_err} !== 4'b0110) begin
            n_err++;
            $display("FAIL nonowner_done: got grant/busy/terr=%b expected 0110", {grant, busy, timeout_err});
        end
        tick();
        n_vec++;
        if (grant !== 2'b01) begin
            n_err++; $display("FAIL nonowner_hold: got %b expected 01", grant);
        end
        clear_inputs();
        repeat (3) tick();
    endtask

    task automatic test_timeout;
        reset_dut();
        req = 2'b11; tx_valid0 = 1'b1; tx_data0 = 8'hA5;
        tick();
        n_vec++;
        if (grant !== 2'b01) begin
            n_err++; $display("FAIL timeout_grant: got %b expected 01", grant);
        end
        repeat (TO) tick();
        n_vec++;
        if ({grant, timeout_err} !== 3'b010) begin
            n_err++; $display("FAIL timeout_early: got grant=%b terr=%b expected 01 0", grant, timeout_err);
        end
        tick();
        n_vec++;
        if ({grant, timeout_err} !== 3'b001) begin
            n_err++; $display("FAIL timeout_fire: got grant=%b terr=%b expected 00 1", grant, timeout_err);
        end
        tick();
        n_vec++;
        if ({grant, timeout_err} !== 3'b000) begin
            n_err++; $display("FAIL timeout_pulse: got grant=%b terr=%b expected 00 0", grant, timeout_err);
        end
        tick();
        n_vec++;
        if (grant !== 2'b10) begin
            n_err++; $display("FAIL timeout_next_owner: got %b expected 10", grant);
        end
        clear_inputs();
        repeat (3) tick();
    endtask

    task automatic test_abort;
        reset_dut();
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        n_vec++;
        if ({grant, timeout_err} !== 3'b000) begin
            n_err++; $display("FAIL abort: got grant=%b terr=%b expected 00 0", grant, timeout_err);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid;
        reset_dut();
        req = 2'b01; tx_valid0 = 1'b1; tx_data0 = 8'h55;
        tick();
        @(negedge clk);
        n_vec++;
        if ({grant, tx_valid, tx_data} !== {2'b01, 1'b1, 8'h55}) begin
            n_err++; $display("FAIL midrst_pre: got grant=%b valid=%b data=%h expected 01 1 55",
                              grant, tx_valid, tx_data);
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({grant, tx_valid, busy, tx_data} !== 12'b0) begin
            n_err++; $display("FAIL midrst_async: got grant=%b valid=%b busy=%b data=%h expected all 0",
                              grant, tx_valid, busy, tx_data);
        end
        tick();
        rst = 1'b1;
        tick();
        n_vec++;
        if (grant !== 2'b01) begin
            n_err++; $display("FAIL midrst_fresh: got %b expected 01", grant);
        end
        clear_inputs();
        repeat (3) tick();
    endtask

    task automatic test_random;
        logic [1:0] e_grant;
        logic [7:0] e_data;
        logic       e_valid, e_busy, e_ack0, e_ack1;
        bit         lazy;
        rst = 1'b0;
        clear_inputs();
        model_reset();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_update();
            #1;
            lazy = ((c / 300) % 2) == 1;
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, lazy ? 63 : 7) == 0) req[i] = ~req[i];
                done[i] = ($urandom_range(0, lazy ? 63 : 11) == 0);
            end
            tx_valid0 = ($urandom_range(0, 3) != 0);
            tx_valid1 = ($urandom_range(0, 3) != 0);
            tx_data0  = 8'($urandom);
            tx_data1  = 8'($urandom);
            tx_ack    = lazy ? ($urandom_range(0, 39) == 0) : 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 599) != 0);
            if (!rst) model_reset();
            @(negedge clk);
            e_grant = m_act ? (m_own ? 2'b10 : 2'b01) : 2'b00;
            e_busy  = m_act || (m_gap > 0);
            e_valid = m_act && (m_own ? tx_valid1 : tx_valid0);
            e_data  = m_act ? (m_own ? tx_data1 : tx_data0) : 8'd0;
            e_ack0  = m_act && !m_own && tx_ack;
            e_ack1  = m_act && m_own && tx_ack;
            n_vec++;
            if ({grant, busy, timeout_err, tx_valid, tx_data, tx_ack0, tx_ack1} !==
                {e_grant, e_busy, m_terr, e_valid, e_data, e_ack0, e_ack1}) begin
                n_err++;
                $display("FAIL random_c%0d: got g=%b b=%b t=%b v=%b d=%h a=%b%b expected g=%b b=%b t=%b v=%b d=%h a=%b%b",
                         c, grant, busy, timeout_err, tx_valid, tx_data, tx_ack0, tx_ack1,
                         e_grant, e_busy, m_terr, e_valid, e_data, e_ack0, e_ack1);
            end
        end
        rst = 1'b1;
        clear_inputs();
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_tie_after_reset();
        test_nonowner_done();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim_time_limit: got no completion expected finish within 2000000 time units");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/tx_arbiter.md
# tx_arbiter

Shares the single byte-wide UART transmit path between two requesters: requester 0 is the sample-dump `transmit` block and requester 1 is the command/status responder. It grants exclusive ownership with a req/grant/done handshake and muxes the owner's `tx_data`/`tx_data_valid` onto the transmitter. It routes `tx_data_ack` back to the owner only. A watchdog revokes a grant from an owner that stalls.

## Interface
- `TIMEOUT_CYCLES`, default 16'd50000: idle cycles (no `tx_ack`) tolerated while granted before the grant is revoked.
- `TO_W`, default 16: width of the watchdog counter; `TIMEOUT_CYCLES` must fit in it.

Ports:
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- `req`  in  2  level request per requester; held until that requester's `done`.
- `grant`  out  2  one-hot or zero grant; registered.
- `done`  in  2  one-cycle pulse from the owner ending its session.
- `tx_data0`, `tx_data1`  in  8  byte from each requester.
- `tx_valid0`, `tx_valid1`  in  1  byte-valid from each requester.
- `tx_ack0`, `tx_ack1`  out  1  ack routed to each requester.
- `tx_data`  out  8  byte to the UART transmitter.
- `tx_valid`  out  1  valid to the UART transmitter.
- `tx_ack`  in  1  ack from the UART transmitter.
- `busy`  out  1  1 whenever the state is not IDLE.
- `timeout_err`  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - With no `req`, stay in IDLE.
  - With exactly one `req`, that requester becomes the owner.
  - With both `req`, the owner is the requester that is not `last_owner` (round-robin).
  - On the transition to GRANT, load `owner` and `last_owner`, and clear the watchdog.
- GRANT:
  - `grant[owner]`=1.
  - `tx_data`/`tx_valid` are combinationally muxed from the owner.
  - `tx_ack` is routed to `tx_ack<owner>` only; the other ack is held at 0.
- GRANT exits to RELEASE on any of:
  - `done[owner]`=1;
  - `req[owner]`=0, treated as an abort;
  - watchdog reaching `TIMEOUT_CYCLES`, which also pulses `timeout_err` for one cycle.
- `done` from the non-owner is ignored in every state.
- Watchdog:
  - Clears on entry to GRANT and on every cycle with `tx_ack`=1.
  - Otherwise increments while in GRANT, saturating at `TIMEOUT_CYCLES`.
- RELEASE: `grant`=0, `tx_valid`=0. Lasts exactly one cycle, then goes to IDLE, so the old owner can drop `req`.
- Outside GRANT: `tx_valid`=0, `tx_data`=8'd0, both acks 0.

## Timing
- Reset values, applied asynchronously while `rst`=0:
  - state IDLE;
  - `grant`=2'b00, `busy`=0, `timeout_err`=0;
  - `tx_valid`=0, `tx_data`=0, acks 0;
  - `last_owner`=1, so requester 0 wins the first tie;
  - watchdog 0.
- Reset mid-session: `grant` drops immediately, the in-flight byte is abandoned, and the next grant is decided fresh from IDLE.
- `req` sampled in IDLE at edge N gives `grant` high after edge N; latency 1 cycle.
- `done[owner]` high at edge N: `grant` low after edge N, RELEASE for one cycle, IDLE after edge N+1.
  - The earliest re-grant is visible after edge N+2.
  - So there is a minimum of 2 grant-low cycles between sessions.
- The mux and ack routing are combinational from `owner` and state; they add zero cycles to the data path.
- Back-to-back sessions with both `req` held alternate 0, 1, 0, … .
- A single requester holding `req` is re-granted every session.
- Timeout:
  - `timeout_err` is high during the cycle after the count reaches `TIMEOUT_CYCLES`.
  - It coincides with `grant` going low.
- `tx_ack` and `done` arriving in the same cycle: the ack is delivered to the owner, then the session ends normally with no `timeout_err`.

## Structure
- Shared package `la_pkg` holds:
  - the state encoding (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2);
  - the requester index constants `REQ_DUMP`=0 and `REQ_CMD`=1.
- One natural sub-module: `tx_watchdog`, a clear/enable saturating counter with a compare output, parameterised by `TO_W` and `TIMEOUT_CYCLES`.
- The FSM, round-robin pointer and mux stay in `tx_arbiter`.

## Test plan
- Single requester:
  - Stimulus: `req`=2'b01, requester 0 sends bytes 8'h01…8'h04 with acks from a UART model.
  - Response: `grant`=2'b01 one cycle after `req`; `tx_ack0` mirrors `tx_ack`; `tx_ack1`=0 throughout.
  - After `done[0]`, `grant`=0 for 2 cycles.
- Tie after reset:
  - Stimulus: `req`=2'b11 immediately after reset release.
  - Response: grant sequence is 2'b01, 2'b10, 2'b01 across three sessions, each ended by `done`.
- Non-owner done:
  - Stimulus: `done[1]` pulsed while requester 0 owns the path.
  - Response: no state change; `grant` stays 2'b01.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=16, owner holds `tx_valid` with `tx_ack` never asserted.
  - Response: after 16 idle cycles, `timeout_err` pulses for 1 cycle and `grant`→0.
  - The other pending requester is granted 2 cycles later.
- Abort: owner drops `req` without `done`; `grant` drops the next cycle and `timeout_err`=0.
- Reset mid-session: `rst`=0 during a byte; `grant`, `tx_valid` and `busy` go to 0 immediately, without waiting for a clock edge.
